// File: rtl/fpu_pkg.sv
// Shared FPU constants and the binary32 field layout used by the int/float converters.
package fpu_pkg;

    localparam int EXP_BIAS = 127;
    localparam int FRAC_W   = 23;
    localparam int EXP_W    = 8;
    localparam int ITOF_LAT = 3;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [FRAC_W-1:0] frac;
    } f32_t;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter; cnt_o is 0 when the input is all zero.
module lzc32 (
    input  logic [31:0] in_i,
    output logic [4:0]  cnt_o,
    output logic        zero_o
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < 32; i++) begin
            if (in_i[i]) begin
                cnt_o = 5'(31 - i);
            end
        end
    end

    assign zero_o = ~|in_i;

endmodule

// File: rtl/itof.sv
// Three-stage signed int32 to binary32 converter with round-to-nearest-even.
module itof
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] op,
    input  logic        valid_in,
    output logic [31:0] result,
    output logic        valid_out
);

    // Handshake: valid_in qualifies op for one cycle and is always accepted (no ready);
    // valid_out marks result for exactly one cycle, three cycles later, in issue order.

    logic                s1_valid_q, s1_sign_q, s1_zero_q;
    logic [31:0]         s1_mag_q;
    logic [31:0]         s1_mag_d;

    logic                s2_valid_q, s2_sign_q, s2_zero_q;
    logic [EXP_W-1:0]    s2_exp_q, s2_exp_d;
    logic [FRAC_W-1:0]   s2_mant_q;
    logic                s2_g_q, s2_r_q, s2_s_q;

    logic [4:0]          lz;
    logic                mag_zero;
    logic [30:0]         norm;

    logic                inc;
    logic [FRAC_W:0]     sum;
    logic [EXP_W-1:0]    exp_out;
    f32_t                result_q, result_d;
    logic                valid_out_q;

    // S1: sign/magnitude split; 0x80000000 negates to itself, which is the right unsigned value.
    assign s1_mag_d = op[31] ? (~op + 32'd1) : op;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_mag_q   <= '0;
        end else begin
            s1_valid_q <= valid_in;
            if (valid_in) begin
                s1_sign_q <= op[31];
                s1_zero_q <= (op == 32'd0);
                s1_mag_q  <= s1_mag_d;
            end
        end
    end

    // S2: normalise. The implicit leading one is shifted out, so only bits [30:0] are kept.
    lzc32 u_lzc (
        .in_i   (s1_mag_q),
        .cnt_o  (lz),
        .zero_o (mag_zero)
    );

    assign norm     = s1_mag_q[30:0] << lz;
    assign s2_exp_d = mag_zero ? '0 : (8'(EXP_BIAS + 31) - {3'b000, lz});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_exp_q   <= '0;
            s2_mant_q  <= '0;
            s2_g_q     <= 1'b0;
            s2_r_q     <= 1'b0;
            s2_s_q     <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_q <= s1_sign_q;
                s2_zero_q <= s1_zero_q;
                s2_exp_q  <= s2_exp_d;
                s2_mant_q <= norm[30:8];
                s2_g_q    <= norm[7];
                s2_r_q    <= norm[6];
                s2_s_q    <= |norm[5:0];
            end
        end
    end

    // S3: on mantissa carry-out the low FRAC_W bits of sum are already zero.
    assign inc     = s2_g_q & (s2_r_q | s2_s_q | s2_mant_q[0]);
    assign sum     = {1'b0, s2_mant_q} + {{FRAC_W{1'b0}}, inc};
    assign exp_out = s2_exp_q + {{(EXP_W-1){1'b0}}, sum[FRAC_W]};

    always_comb begin
        result_d = '0;
        if (!s2_zero_q) begin
            result_d.sign = s2_sign_q;
            result_d.exp  = exp_out;
            result_d.frac = sum[FRAC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out_q <= 1'b0;
            result_q    <= '0;
        end else begin
            valid_out_q <= s2_valid_q;
            if (s2_valid_q) begin
                result_q <= result_d;
            end
        end
    end

    assign result    = result_q;
    assign valid_out = valid_out_q;

endmodule

// File: tb/tb_itof.sv
// Directed and model-backed checks for the itof converter.
module tb_itof;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] op;
    logic        valid_in;
    logic [31:0] result;
    logic        valid_out;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_q[$];
    logic [1:0]  v_sr;
    logic        exp_vo;
    logic [31:0] exp_res;

    always #5 clk = ~clk;

    itof dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .valid_in  (valid_in),
        .result    (result),
        .valid_out (valid_out)
    );

    // Reference: exact integer magnitude, explicit floor/remainder rounding.
    function automatic logic [31:0] ref_itof(input logic [31:0] v);
        longint a, q, rem, half;
        int     e;
        logic   s;
        if (v == 32'd0) return 32'h0000_0000;
        s = v[31];
        a = longint'({32'h0, v});
        if (s) a = 64'sh1_0000_0000 - a;
        e = 0;
        while ((longint'(1) << (e + 1)) <= a) e++;
        if (e > 23) begin
            q    = a >> (e - 23);
            rem  = a - (q << (e - 23));
            half = longint'(1) << (e - 24);
            if (rem > half || (rem == half && q[0])) q = q + 1;
        end else begin
            q = a << (23 - e);
        end
        if (q == (longint'(1) << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        return {s, 8'(e + 127), q[22:0]};
    endfunction

    // Driver + scoreboard step: present one beat, advance one edge, derive expected outputs.
    task automatic cycle(input logic v, input logic [31:0] x, input logic [31:0] want);
        valid_in = v;
        op       = x;
        if (v) exp_q.push_back(want);
        @(posedge clk);
        #1;
        exp_vo = v_sr[1];
        if (exp_vo && exp_q.size() > 0) exp_res = exp_q.pop_front();
        v_sr = {v_sr[0], v};
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        valid_in = 1'b0;
        op       = 32'h0;
        v_sr     = 2'b00;
        exp_res  = 32'h0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset valid_out got %b want 0", valid_out);
        end
        n_cmp++;
        if (result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset result got %h want 00000000", result);
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, $urandom, 32'h0);
            n_cmp++;
            if (valid_out !== exp_vo || result !== exp_res) begin
                n_fail++;
                $display("FAIL reset_idle got vo=%b res=%h want vo=%b res=%h", valid_out, result, exp_vo, exp_res);
            end
        end
    endtask

    // Isolated operands: valid_out must appear exactly once, on the third cycle.
    task automatic test_basic();
        logic [31:0] ops[6]   = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000,
                                  32'h0000_0002, 32'hFFFF_FFFE, 32'h0000_0064};
        logic [31:0] wants[6] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000,
                                  32'h4000_0000, 32'hC000_0000, 32'h42C8_0000};
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 0) cycle(1'b1, ops[i], wants[i]);
                else        cycle(1'b0, $urandom, 32'h0);
                n_cmp++;
                if (valid_out !== exp_vo) begin
                    n_fail++;
                    $display("FAIL basic_valid op=%h step=%0d got %b want %b", ops[i], c, valid_out, exp_vo);
                end
                n_cmp++;
                if (result !== exp_res) begin
                    n_fail++;
                    $display("FAIL basic_result op=%h step=%0d got %h want %h", ops[i], c, result, exp_res);
                end
            end
        end
    endtask

    task automatic test_rounding();
        logic [31:0] ops[9]   = '{32'h0100_0001, 32'h0100_0003, 32'h7FFF_FFFF,
                                  32'h0200_0003, 32'hFEFF_FFFD, 32'h0000_0007,
                                  32'h0, 32'h0, 32'h0};
        logic [31:0] wants[9] = '{32'h4B80_0000, 32'h4B80_0002, 32'h4F00_0000,
                                  32'h4C00_0001, 32'hCB80_0002, 32'h40E0_0000,
                                  32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 9; i++) begin
            cycle(i < 6, (i < 6) ? ops[i] : $urandom, wants[i]);
            n_cmp++;
            if (valid_out !== exp_vo || result !== exp_res) begin
                n_fail++;
                $display("FAIL rounding step=%0d got vo=%b res=%h want vo=%b res=%h", i, valid_out, result, exp_vo, exp_res);
            end
        end
    endtask

    task automatic test_extremes();
        logic [31:0] ops[8]   = '{32'h8000_0000, 32'h0, 32'h00FF_FFFF, 32'h8000_0001,
                                  32'h0, 32'h4000_0000, 32'h0, 32'h0};
        logic [31:0] wants[8] = '{32'hCF00_0000, 32'h0, 32'h4B7F_FFFF, 32'hCF00_0000,
                                  32'h0, 32'h4E80_0000, 32'h0, 32'h0};
        logic        vs[8]    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            cycle(vs[i], vs[i] ? ops[i] : $urandom, wants[i]);
            n_cmp++;
            if (valid_out !== exp_vo || result !== exp_res) begin
                n_fail++;
                $display("FAIL extremes step=%0d got vo=%b res=%h want vo=%b res=%h", i, valid_out, result, exp_vo, exp_res);
            end
        end
    endtask

    // Ten operands with random bubbles; result must hold its value on bubble cycles.
    task automatic test_stream();
        int          sent = 0;
        int          steps = 0;
        logic        v;
        logic [31:0] x;
        while (sent < 10 || steps < 3) begin
            v = (sent < 10) && ($urandom_range(0, 2) != 0);
            x = $urandom;
            if (v) sent++;
            if (sent >= 10 && !v) steps++;
            cycle(v, x, ref_itof(x));
            n_cmp++;
            if (valid_out !== exp_vo || result !== exp_res) begin
                n_fail++;
                $display("FAIL stream sent=%0d got vo=%b res=%h want vo=%b res=%h", sent, valid_out, result, exp_vo, exp_res);
            end
        end
    endtask

    // Back-to-back: +-2^k, +-(2^k+-1) for every k, then random operands.
    task automatic test_back_to_back();
        logic [31:0] vals[$];
        logic [31:0] p;
        for (int k = 0; k < 32; k++) begin
            p = 32'h1 << k;
            vals.push_back(p);
            vals.push_back(-p);
            vals.push_back(p + 32'h1);
            vals.push_back(p - 32'h1);
            vals.push_back(-(p + 32'h1));
            vals.push_back(-(p - 32'h1));
        end
        for (int i = 0; i < 1000; i++) vals.push_back($urandom);
        for (int i = 0; i < vals.size() + 3; i++) begin
            if (i < vals.size()) cycle(1'b1, vals[i], ref_itof(vals[i]));
            else                 cycle(1'b0, $urandom, 32'h0);
            n_cmp++;
            if (valid_out !== exp_vo || result !== exp_res) begin
                n_fail++;
                $display("FAIL back_to_back idx=%0d got vo=%b res=%h want vo=%b res=%h", i, valid_out, result, exp_vo, exp_res);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] ops[3] = '{32'h0000_0005, 32'h0000_0006, 32'h0000_0007};
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, ops[i], ref_itof(ops[i]));
            n_cmp++;
            if (valid_out !== exp_vo || result !== exp_res) begin
                n_fail++;
                $display("FAIL midreset_fill step=%0d got vo=%b res=%h want vo=%b res=%h", i, valid_out, result, exp_vo, exp_res);
            end
        end
        valid_in = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (valid_out !== 1'b0 || result !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_async got vo=%b res=%h want vo=0 res=00000000", valid_out, result);
        end
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b1;
        v_sr    = 2'b00;
        exp_res = 32'h0;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, $urandom, 32'h0);
            n_cmp++;
            if (valid_out !== exp_vo || result !== exp_res) begin
                n_fail++;
                $display("FAIL midreset_after step=%0d got vo=%b res=%h want vo=%b res=%h", i, valid_out, result, exp_vo, exp_res);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_extremes();
        test_stream();
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
